// File: rtl/spi_mux_pkg.sv
// Shared definitions for the SPI-fed LED mux front-end: FSM encoding,
// command opcodes and the default lane count.
package spi_mux_pkg;

  localparam int unsigned NUM_LANES_DEF = 8;

  typedef enum logic [3:0] {
    IDLE  = 4'h0,
    CMD   = 4'h1,
    EXEC  = 4'h2,
    PASS  = 4'h3,
    DRAIN = 4'h4
  } state_e;

  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_SET_EN  = 4'h1;
  localparam logic [3:0] OP_STREAM  = 4'h2;
  localparam logic [3:0] OP_CLR_CFG = 4'h3;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with single-cycle
// rise/fall pulses derived from the synchronized level.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Clearing to 0 means a pin already low at reset release never looks like a fall.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_mux_ctrl.sv
// SPI command front-end for the LED output mux. Define
// SPI_MUX_CTRL_STREAM_TIMEOUT_EN to abort idle pass-through streams.
module spi_mux_ctrl
  import spi_mux_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned NUM_LANES      = NUM_LANES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         spi_nCS,
  input  logic                         spi_sck,
  input  logic                         spi_mosi,
  output logic                         spi_miso,
  output logic                         spi_miso_oe,
  output logic [$clog2(NUM_LANES)-1:0] out_sel,
  output logic [3:0]                   out_en,
  output logic                         pass_active,
  output logic                         buffer_oe,
  output logic                         frame_err,
  output logic [2:0]                   status
);

  localparam int unsigned SEL_W = $clog2(NUM_LANES);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  logic ncs_rise, ncs_fall, sck_rise, sck_fall, mosi_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
    .clk(clk), .reset(reset), .d_i(spi_nCS),
    .sync_o(), .rise_o(ncs_rise), .fall_o(ncs_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(clk), .reset(reset), .d_i(spi_sck),
    .sync_o(), .rise_o(sck_rise), .fall_o(sck_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .reset(reset), .d_i(spi_mosi),
    .sync_o(mosi_s), .rise_o(), .fall_o()
  );

  state_e           state_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       cmd_q;
  logic [7:0]       stat_q;
  logic             miso_q, miso_oe_q;
  logic [SEL_W-1:0] out_sel_q;
  logic [3:0]       out_en_q;
  logic             pass_q, buf_oe_q, err_q, sticky_q;

  logic [3:0] opc, arg;
  assign opc = cmd_q[7:4];
  assign arg = cmd_q[3:0];

`ifdef SPI_MUX_CTRL_STREAM_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  logic [TMR_W-1:0] tmr_q;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      cmd_q     <= '0;
      stat_q    <= '0;
      miso_q    <= 1'b0;
      miso_oe_q <= 1'b0;
      out_sel_q <= '0;
      out_en_q  <= '0;
      pass_q    <= 1'b0;
      buf_oe_q  <= 1'b0;
      err_q     <= 1'b0;
      sticky_q  <= 1'b0;
`ifdef SPI_MUX_CTRL_STREAM_TIMEOUT_EN
      tmr_q     <= '0;
`endif
    end else begin
      buf_oe_q <= 1'b1;
      err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ncs_fall) begin
            state_q   <= CMD;
            bit_cnt_q <= '0;
            stat_q    <= {out_en_q, 3'(out_sel_q), sticky_q};
            miso_q    <= out_en_q[3];
            miso_oe_q <= 1'b1;
          end
        end
        CMD: begin
          // A deselect always wins over a coincident 8th SCK rise.
          if (ncs_rise) begin
            state_q   <= IDLE;
            err_q     <= 1'b1;
            sticky_q  <= 1'b1;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
          end else begin
            if (sck_rise) begin
              cmd_q     <= {cmd_q[6:0], mosi_s};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) state_q <= EXEC;
            end
            if (sck_fall) begin
              stat_q <= {stat_q[6:0], 1'b0};
              miso_q <= stat_q[6];
            end
          end
        end
        EXEC: begin
          miso_q    <= 1'b0;
          miso_oe_q <= ~ncs_rise;
          state_q   <= ncs_rise ? IDLE : DRAIN;
          case (opc)
            OP_NOP: ;
            OP_SET_EN: out_en_q <= arg;
            OP_STREAM: begin
              if (32'(arg) < NUM_LANES) begin
                out_sel_q <= arg[SEL_W-1:0];
                pass_q    <= ~ncs_rise;
                if (!ncs_rise) state_q <= PASS;
`ifdef SPI_MUX_CTRL_STREAM_TIMEOUT_EN
                tmr_q     <= TMR_RELOAD;
`endif
              end else begin
                err_q    <= 1'b1;
                sticky_q <= 1'b1;
              end
            end
            OP_CLR_CFG: begin
              out_en_q  <= '0;
              out_sel_q <= '0;
              sticky_q  <= 1'b0;
            end
            default: begin
              err_q    <= 1'b1;
              sticky_q <= 1'b1;
            end
          endcase
        end
        PASS: begin
          if (ncs_rise) begin
            pass_q    <= 1'b0;
            miso_oe_q <= 1'b0;
            state_q   <= IDLE;
          end
`ifdef SPI_MUX_CTRL_STREAM_TIMEOUT_EN
          else if (sck_rise) begin
            tmr_q <= TMR_RELOAD;
          end else if (tmr_q == '0) begin
            pass_q   <= 1'b0;
            err_q    <= 1'b1;
            sticky_q <= 1'b1;
            state_q  <= DRAIN;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
`endif
        end
        DRAIN: begin
          if (ncs_rise) begin
            miso_oe_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = miso_oe_q;
  assign out_sel     = out_sel_q;
  assign out_en      = out_en_q;
  assign pass_active = pass_q;
  assign buffer_oe   = buf_oe_q;
  assign frame_err   = err_q;
  assign status      = {sticky_q, pass_q, ~reset};

endmodule

// File: tb/tb_spi_mux_ctrl.sv
// Randomized self-checking bench for spi_mux_ctrl against a frame-level
// model of the command set.
module tb_spi_mux_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic spi_nCS = 1'b1, spi_sck = 1'b0, spi_mosi = 1'b0;
  logic spi_miso, spi_miso_oe, pass_active, buffer_oe, frame_err;
  logic [2:0] out_sel, status;
  logic [3:0] out_en;

  int n_checks = 0;
  int n_fail = 0;
  int err_pulses = 0;
  bit pass_seen = 1'b0;

  // Frame-level reference state
  logic [3:0] m_en = '0;
  logic [2:0] m_sel = '0;
  logic       m_sticky = 1'b0;
  int         m_err = 0;

  always #10 clk = ~clk;

  spi_mux_ctrl #(.SYNC_STAGES(2), .NUM_LANES(8), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .spi_nCS(spi_nCS), .spi_sck(spi_sck),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .out_sel(out_sel), .out_en(out_en), .pass_active(pass_active),
    .buffer_oe(buffer_oe), .frame_err(frame_err), .status(status)
  );

  always @(negedge clk) begin
    if (frame_err === 1'b1) err_pulses++;
    if (pass_active === 1'b1) pass_seen = 1'b1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] m_status();
    return {m_en, m_sel, m_sticky};
  endfunction

  // Applies one frame of nrises SCK rises carrying cmd; returns whether it opens a stream.
  function automatic bit model_frame(input logic [7:0] cmd, input int nrises);
    if (nrises < 8) begin
      m_err++;
      m_sticky = 1'b1;
      return 1'b0;
    end
    case (cmd[7:4])
      4'h0: ;
      4'h1: m_en = cmd[3:0];
      4'h2: begin
        if (cmd[3] == 1'b0) begin
          m_sel = cmd[2:0];
          return 1'b1;
        end
        m_err++;
        m_sticky = 1'b1;
      end
      4'h3: begin
        m_en = '0;
        m_sel = '0;
        m_sticky = 1'b0;
      end
      default: begin
        m_err++;
        m_sticky = 1'b1;
      end
    endcase
    return 1'b0;
  endfunction

  task automatic cs_low();
    @(negedge clk);
    spi_nCS = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_high();
    @(negedge clk);
    spi_nCS = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic sck_bit(input logic b, output logic miso_s);
    @(negedge clk);
    spi_mosi = b;
    repeat (4) @(negedge clk);
    miso_s = spi_miso;
    spi_sck = 1'b1;
    repeat (5) @(negedge clk);
    spi_sck = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] cmd, input int nrises, output logic [7:0] mb);
    logic s;
    mb = '0;
    cs_low();
    for (int i = 0; i < nrises; i++) begin
      sck_bit((i < 8) ? cmd[7-i] : 1'($urandom), s);
      if (i < 8) mb[7-i] = s;
    end
    cs_high();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      spi_sck = ~spi_sck;
      spi_nCS = ~spi_nCS;
      spi_mosi = 1'($urandom);
    end
    n_checks++;
    if ({spi_miso, spi_miso_oe, out_sel, out_en, pass_active, buffer_oe, frame_err} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got miso=%b oe=%b sel=%0d en=%h pass=%b boe=%b err=%b, want all 0",
               spi_miso, spi_miso_oe, out_sel, out_en, pass_active, buffer_oe, frame_err);
    end
    n_checks++;
    if (status !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_status: got %b want 001", status);
    end
    spi_nCS = 1'b1;
    spi_sck = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (buffer_oe !== 1'b1 || status !== 3'b000) begin
      n_fail++;
      $display("FAIL post_reset: got buffer_oe=%b status=%b want 1 / 000", buffer_oe, status);
    end
    repeat (8) @(negedge clk);
    n_checks++;
    if (err_pulses !== 0 || spi_miso_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got err_pulses=%0d miso_oe=%b want 0 / 0", err_pulses, spi_miso_oe);
    end
  endtask

  task automatic test_set_en();
    logic [7:0] mb, exp_mb;
    bit p;
    exp_mb = m_status();
    run_frame(8'h1A, 8, mb);
    p = model_frame(8'h1A, 8);
    n_checks++;
    if (mb !== exp_mb) begin
      n_fail++;
      $display("FAIL set_en_miso: got %h want %h", mb, exp_mb);
    end
    n_checks++;
    if (out_en !== 4'b1010 || err_pulses !== m_err || p) begin
      n_fail++;
      $display("FAIL set_en: got out_en=%b err=%0d want 1010 err=%0d", out_en, err_pulses, m_err);
    end
    exp_mb = m_status();
    run_frame(8'h00, 8, mb);
    p = model_frame(8'h00, 8);
    n_checks++;
    if (mb !== 8'hA0 || mb !== exp_mb) begin
      n_fail++;
      $display("FAIL set_en_readback: got %h want A0", mb);
    end
  endtask

  task automatic test_stream();
    logic [7:0] exp_mb, mb;
    logic s;
    logic [3:0] en_before;
    logic [2:0] win;
    bit p;
    en_before = out_en;
    exp_mb = m_status();
    cs_low();
    for (int i = 0; i < 8; i++) begin
      sck_bit(((8'h25 >> (7 - i)) & 8'h01) != 0, s);
      mb[7-i] = s;
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (pass_active !== 1'b1 || out_sel !== 3'd5 || mb !== exp_mb) begin
      n_fail++;
      $display("FAIL stream_start: got pass=%b sel=%0d miso=%h want 1 5 %h", pass_active, out_sel, mb, exp_mb);
    end
    for (int i = 0; i < 16; i++) sck_bit(1'($urandom), s);
    n_checks++;
    if (pass_active !== 1'b1 || spi_miso !== 1'b0 || spi_miso_oe !== 1'b1) begin
      n_fail++;
      $display("FAIL stream_hold: got pass=%b miso=%b oe=%b want 1 0 1", pass_active, spi_miso, spi_miso_oe);
    end
    @(negedge clk);
    spi_nCS = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      win[k] = pass_active;
    end
    n_checks++;
    if (win !== 3'b011) begin
      n_fail++;
      $display("FAIL stream_end_timing: got pass after 1..3 cycles=%b%b%b want 1 1 0", win[0], win[1], win[2]);
    end
    repeat (6) @(negedge clk);
    p = model_frame(8'h25, 24);
    n_checks++;
    if (out_en !== en_before || err_pulses !== m_err || spi_miso_oe !== 1'b0 || !p) begin
      n_fail++;
      $display("FAIL stream_after: got en=%h err=%0d oe=%b want en=%h err=%0d oe=0",
               out_en, err_pulses, spi_miso_oe, en_before, m_err);
    end
  endtask

  task automatic test_short_frame();
    logic [7:0] mb, exp_mb;
    bit p;
    run_frame(8'h1F, 5, mb);
    p = model_frame(8'h1F, 5);
    n_checks++;
    if (err_pulses !== m_err || status[2] !== 1'b1 || out_en !== m_en || out_sel !== m_sel || p) begin
      n_fail++;
      $display("FAIL short_frame: got err=%0d sticky=%b en=%h sel=%0d want err=%0d sticky=1 en=%h sel=%0d",
               err_pulses, status[2], out_en, out_sel, m_err, m_en, m_sel);
    end
    exp_mb = m_status();
    run_frame(8'h30, 8, mb);
    p = model_frame(8'h30, 8);
    n_checks++;
    if (mb !== exp_mb || status[2] !== 1'b0 || out_en !== 4'h0 || out_sel !== 3'd0) begin
      n_fail++;
      $display("FAIL clr_cfg: got miso=%h sticky=%b en=%h sel=%0d want miso=%h 0 0 0",
               mb, status[2], out_en, out_sel, exp_mb);
    end
  endtask

  task automatic test_illegal();
    logic [7:0] mb;
    bit p;
    logic [7:0] cmds [2] = '{8'hF0, 8'h28};
    run_frame(8'h15, 8, mb);
    p = model_frame(8'h15, 8);
    foreach (cmds[j]) begin
      pass_seen = 1'b0;
      run_frame(cmds[j], 16, mb);
      p = model_frame(cmds[j], 16);
      n_checks++;
      if (err_pulses !== m_err || status[2] !== 1'b1 || pass_seen !== 1'b0 || out_en !== m_en ||
          out_sel !== m_sel || spi_miso_oe !== 1'b0 || p) begin
        n_fail++;
        $display("FAIL illegal_%h: got err=%0d sticky=%b pass_seen=%b en=%h sel=%0d oe=%b want err=%0d 1 0 %h %0d 0",
                 cmds[j], err_pulses, status[2], pass_seen, out_en, out_sel, spi_miso_oe, m_err, m_en, m_sel);
      end
    end
  endtask

  task automatic test_ncs_race();
    logic s;
    bit p;
    cs_low();
    for (int i = 0; i < 7; i++) sck_bit(((8'h1C >> (7 - i)) & 8'h01) != 0, s);
    @(negedge clk);
    spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    spi_sck = 1'b1;
    spi_nCS = 1'b1;
    repeat (5) @(negedge clk);
    spi_sck = 1'b0;
    repeat (8) @(negedge clk);
    p = model_frame(8'h1C, 7);
    n_checks++;
    if (err_pulses !== m_err || out_en !== m_en || status[2] !== 1'b1 || p) begin
      n_fail++;
      $display("FAIL ncs_race: got err=%0d en=%h sticky=%b want err=%0d en=%h sticky=1",
               err_pulses, out_en, status[2], m_err, m_en);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic s;
    logic [7:0] mb;
    bit p;
    cs_low();
    for (int i = 0; i < 3; i++) sck_bit(1'b1, s);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({spi_miso_oe, out_en, out_sel, status[2:1]} !== 10'h0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: got oe=%b en=%h sel=%0d status=%b want all 0", spi_miso_oe, out_en, out_sel, status);
    end
    reset = 1'b1;
    m_en = '0;
    m_sel = '0;
    m_sticky = 1'b0;
    for (int i = 0; i < 8; i++) sck_bit(((8'h1F >> (7 - i)) & 8'h01) != 0, s);
    repeat (4) @(negedge clk);
    n_checks++;
    if (out_en !== 4'h0 || spi_miso_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_ignored: got en=%h oe=%b want 0 0", out_en, spi_miso_oe);
    end
    cs_high();
    n_checks++;
    if (err_pulses !== m_err) begin
      n_fail++;
      $display("FAIL reset_mid_noerr: got err=%0d want %0d", err_pulses, m_err);
    end
    run_frame(8'h13, 8, mb);
    p = model_frame(8'h13, 8);
    n_checks++;
    if (out_en !== 4'h3 || mb !== 8'h00 || p) begin
      n_fail++;
      $display("FAIL reset_mid_next: got en=%h miso=%h want 3 00", out_en, mb);
    end
  endtask

  task automatic test_random();
    logic [7:0] cmd, mb, exp_mb;
    int nr;
    bit exp_pass;
    for (int f = 0; f < 40; f++) begin
      cmd[7:4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      cmd[3:0] = 4'($urandom);
      nr = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : 8 + $urandom_range(0, 10);
      exp_mb = m_status();
      pass_seen = 1'b0;
      run_frame(cmd, nr, mb);
      exp_pass = model_frame(cmd, nr);
      n_checks++;
      if ((nr >= 8 && mb !== exp_mb) || out_en !== m_en || out_sel !== m_sel || status[2] !== m_sticky ||
          err_pulses !== m_err || pass_seen !== exp_pass || pass_active !== 1'b0 || spi_miso_oe !== 1'b0) begin
        n_fail++;
        $display("FAIL random_%0d cmd=%h rises=%0d: got miso=%h en=%h sel=%0d sticky=%b err=%0d pass_seen=%b want %h %h %0d %b %0d %b",
                 f, cmd, nr, mb, out_en, out_sel, status[2], err_pulses, pass_seen,
                 exp_mb, m_en, m_sel, m_sticky, m_err, exp_pass);
      end
    end
  endtask

  task automatic test_stream_idle();
    logic s;
    bit p;
    logic [3:0] en_before;
    int n;
    en_before = out_en;
    cs_low();
    for (int i = 0; i < 8; i++) sck_bit(((8'h21 >> (7 - i)) & 8'h01) != 0, s);
    sck_bit(1'b1, s);
    @(negedge clk);
    spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    spi_sck = 1'b1;
    p = model_frame(8'h21, 10);
`ifdef SPI_MUX_CTRL_STREAM_TIMEOUT_EN
    n = 0;
    while (n < 400 && pass_active === 1'b1) begin
      @(negedge clk);
      n++;
      if (n == 5) spi_sck = 1'b0;
    end
    spi_sck = 1'b0;
    repeat (3) @(negedge clk);
    m_err++;
    m_sticky = 1'b1;
    n_checks++;
    if (n !== 103 || err_pulses !== m_err || status[2] !== 1'b1 || out_sel !== 3'd1 || !p) begin
      n_fail++;
      $display("FAIL stream_timeout: got fall after %0d cycles err=%0d sticky=%b sel=%0d want 103 %0d 1 1",
               n, err_pulses, status[2], out_sel, m_err);
    end
`else
    n = 0;
    repeat (5) @(negedge clk);
    spi_sck = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (pass_active === 1'b1) n++;
    end
    n_checks++;
    if (n !== 300 || err_pulses !== m_err || out_sel !== 3'd1 || !p) begin
      n_fail++;
      $display("FAIL stream_persist: got pass cycles=%0d err=%0d sel=%0d want 300 %0d 1", n, err_pulses, out_sel, m_err);
    end
`endif
    cs_high();
    n_checks++;
    if (pass_active !== 1'b0 || spi_miso_oe !== 1'b0 || out_en !== en_before) begin
      n_fail++;
      $display("FAIL stream_idle_end: got pass=%b oe=%b en=%h want 0 0 %h", pass_active, spi_miso_oe, out_en, en_before);
    end
  endtask

  initial begin
    test_reset();
    test_set_en();
    test_stream();
    test_short_frame();
    test_illegal();
    test_ncs_race();
    test_reset_mid_frame();
    test_random();
    test_stream_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_mux_ctrl.md
Name: spi_mux_ctrl

Overview:
- Command front-end and configuration controller for the SPI-fed LED output mux.
- Oversamples the SPI bus on the 50 MHz system clock and decodes the first byte of each chip-select frame as a command.
- Commands set the differential-driver enables, or select one of the 8 output lanes and open a pass-through stream for the rest of the frame.
- Drives the mux lane select and enables; returns a status byte on MISO while the command byte shifts in.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on spi_nCS/spi_sck/spi_mosi (min 2).
- NUM_LANES, 8, output lanes; lane select width is clog2(NUM_LANES).
- TIMEOUT_CYCLES, 50000, clk cycles without an SCK rising edge before a stream is aborted (used only with the optional feature).

Ports:
- clk  in  1  master clock, 50 MHz.
- reset  in  1  synchronous reset, active low.
- spi_nCS  in  1  SPI chip select, active low, asynchronous to clk.
- spi_sck  in  1  SPI clock (mode 0), asynchronous.
- spi_mosi  in  1  SPI master output.
- spi_miso  out  1  status bit, MSB-first.
- spi_miso_oe  out  1  MISO tristate enable; 1 only while a frame is selected.
- out_sel  out  3  lane select for the mux datapath.
- out_en  out  4  differential-driver enables.
- pass_active  out  1  high while the mux routes synchronized MOSI to lane out_sel.
- buffer_oe  out  1  level-translator enable.
- frame_err  out  1  one-cycle error pulse.
- status  out  3  LEDs: [0]=~reset, [1]=pass_active, [2]=sticky error.

Behaviour:
- Reset: all of the following clear synchronously while reset=0, and the FSM goes to IDLE:
  - out_sel=0, out_en=0, pass_active=0, buffer_oe=0
  - spi_miso=0, spi_miso_oe=0, frame_err=0, status[2:1]=0
  - bit counter and shift registers
- Post-reset: buffer_oe=1 from the first cycle after reset deasserts.
- Input sync and edge detect:
  - Inputs pass SYNC_STAGES flops; edges are detected on the synchronized values.
  - An SCK rise or nCS change takes effect SYNC_STAGES+1 clk cycles after the pin change.
- FSM states: IDLE, CMD, EXEC, PASS, DRAIN.
- IDLE:
  - nCS falls -> CMD; bit counter=0.
  - Load status byte {out_en[3:0], out_sel[2:0], sticky_err}.
  - spi_miso_oe=1 and spi_miso=status MSB.
- CMD:
  - On each SCK rise: shift synchronized MOSI in MSB-first; counter+1.
  - On each SCK fall: shift the next status bit onto spi_miso.
  - After the 8th rise -> EXEC.
  - nCS rises with counter<8 -> IDLE; frame_err pulse; sticky_err=1; no config change.
- EXEC: exactly 1 cycle. Decode opcode=cmd[7:4], arg=cmd[3:0]:
  - 0x0 NOP -> DRAIN.
  - 0x1 SET_EN: out_en<=arg -> DRAIN.
  - 0x2 STREAM: out_sel<=arg[2:0]; pass_active<=1 -> PASS. arg[3]=1 -> treated as illegal.
  - 0x3 CLR_CFG: out_en<=0, out_sel<=0, sticky_err<=0 -> DRAIN.
  - Other opcodes: illegal -> frame_err pulse, sticky_err=1 -> DRAIN.
- PASS:
  - pass_active=1; SCK edges ignored by the controller.
  - nCS rises -> pass_active<=0 on the same cycle the edge is detected -> IDLE.
- DRAIN: ignore SCK until nCS rises -> IDLE.
- spi_miso_oe: 0 in IDLE once nCS is high.
- spi_miso after the status byte: 0 in PASS and DRAIN.
- nCS rise on the same cycle as the 8th SCK rise: nCS wins, frame counted as short (error).
- Config persistence: out_en/out_sel hold their values across frames until changed.
- Reset mid-frame:
  - Immediate clear; the FSM re-enters IDLE.
  - A still-low nCS is not treated as a new frame until it is seen high first.

Optional Feature:
- Macro: SPI_MUX_CTRL_STREAM_TIMEOUT_EN.
- Defined:
  - In PASS, a counter reloads on every SCK rise.
  - If TIMEOUT_CYCLES elapse with no rise: pass_active<=0, frame_err pulse, sticky_err=1 -> DRAIN.
- Undefined: PASS persists indefinitely while nCS is low; no timeout logic is synthesized.

Decomposition:
- Package spi_mux_pkg holds:
  - FSM state encoding (4-bit, matching the existing IDLE/SHIFT/RESET style)
  - opcode constants OP_NOP/OP_SET_EN/OP_STREAM/OP_CLR_CFG
  - NUM_LANES default
- Sub-module spi_sync_edge: SYNC_STAGES synchronizer plus rise/fall pulse outputs, instantiated once per SPI input.

Test Plan:
- Reset: hold reset=0 for 4 cycles with SPI toggling -> all outputs 0. Release -> buffer_oe=1 next cycle, FSM IDLE.
- SET_EN: frame byte 0x1A -> out_en=4'b1010 after EXEC; no frame_err; next frame's MISO byte reads 0xA0.
- STREAM: frame 0x25 then 16 data bits -> out_sel=5; pass_active=1 from EXEC until SYNC_STAGES+1 cycles after nCS rises; out_en unchanged.
- Short frame: nCS high after 5 SCK rises -> single frame_err pulse; status[2]=1; out_en/out_sel unchanged. Frame 0x30 -> status[2]=0, out_en=0.
- Illegal opcode: 0xF0 -> frame_err pulse; remaining 8 SCK edges ignored; return to IDLE on nCS high.
- Timeout (macro defined, TIMEOUT_CYCLES=100): STREAM 0x21, stop SCK with nCS low -> pass_active falls exactly 100 cycles after the last synchronized rise; frame_err pulses.
